// File: rtl/bf_prog_loader.sv
// Brainfuck program loader: filters a UART byte stream to opcodes, packs them to
// 3-bit codes, writes them to instruction memory and checks bracket balance/capacity.
module bf_prog_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [7:0]  TERM_BYTE = 8'h21
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_wdata,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              loaded,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_CLOSE    = 2'd2;
    localparam logic [1:0] ERR_OPEN     = 2'd3;

    localparam logic [2:0] OP_OPEN  = 3'd4;
    localparam logic [2:0] OP_CLOSE = 3'd5;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  ptr_q,       ptr_d;
    logic [CNT_W-1:0]  depth_q,     depth_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [2:0]        mem_wdata_q, mem_wdata_d;
    logic [1:0]        err_code_q,  err_code_d;

    logic       accept_c;
    logic       is_op_c;
    logic [2:0] op_c;

    // Opcode map; anything else is a comment unless it is the terminator
    always_comb begin
        is_op_c = 1'b1;
        op_c    = 3'd0;
        case (rx_data)
            8'h2B:   op_c = 3'd0;
            8'h2D:   op_c = 3'd1;
            8'h3E:   op_c = 3'd2;
            8'h3C:   op_c = 3'd3;
            8'h5B:   op_c = 3'd4;
            8'h5D:   op_c = 3'd5;
            8'h2E:   op_c = 3'd6;
            8'h2C:   op_c = 3'd7;
            default: is_op_c = 1'b0;
        endcase
    end

    // start wins over a same-cycle byte
    assign accept_c = (state_q == ST_RECV) && !start;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        depth_d     = depth_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_code_d  = err_code_q;

        if (start) begin
            state_d    = ST_RECV;
            ptr_d      = '0;
            depth_d    = '0;
            err_code_d = ERR_NONE;
        end else if (accept_c && rx_valid) begin
            if (rx_data == TERM_BYTE) begin
                if (depth_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_OPEN;
                end
            end else if (is_op_c) begin
                // Unmatched ']' is reported ahead of a full memory
                if (op_c == OP_CLOSE && depth_q == '0) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_CLOSE;
                end else if (ptr_q[ADDR_W]) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_OVERFLOW;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q[ADDR_W-1:0];
                    mem_wdata_d = op_c;
                    ptr_d       = ptr_q + CNT_W'(1);
                    if (op_c == OP_OPEN)  depth_d = depth_q + CNT_W'(1);
                    if (op_c == OP_CLOSE) depth_d = depth_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            depth_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            depth_q     <= depth_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_code_q  <= err_code_d;
        end
    end

    assign rx_ready  = accept_c;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign prog_len  = ptr_q;
    assign busy      = (state_q == ST_RECV);
    assign loaded    = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_bf_prog_loader.sv
// Scoreboard bench for bf_prog_loader: a byte-level reference model predicts writes
// and status; a monitor pops expected writes whenever mem_we is seen.
module tb_bf_prog_loader;

    localparam int unsigned AW  = 4;
    localparam int          CAP = 16;

    localparam int M_IDLE = 0;
    localparam int M_RECV = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic          CLK = 1'b0;
    logic          resetn;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_wdata;
    logic [AW:0]   prog_len;
    logic          busy;
    logic          loaded;
    logic          error;
    logic [1:0]    err_code;

    int vectors = 0;
    int miscompares = 0;

    int m_state = M_IDLE;
    int m_cnt   = 0;
    int m_depth = 0;
    int m_code  = 0;
    logic [6:0] exp_q[$];

    bf_prog_loader #(.ADDR_W(AW), .TERM_BYTE(8'h21)) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .prog_len  (prog_len),
        .busy      (busy),
        .loaded    (loaded),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    function automatic int decode(input logic [7:0] b);
        case (b)
            "+": return 0;
            "-": return 1;
            ">": return 2;
            "<": return 3;
            "[": return 4;
            "]": return 5;
            ".": return 6;
            ",": return 7;
            default: return -1;
        endcase
    endfunction

    // Reference: apply one accepted byte to the abstract loader state
    task automatic model_byte(input logic [7:0] b);
        int op;
        op = decode(b);
        if (b == 8'h21) begin
            if (m_depth == 0) m_state = M_DONE;
            else begin m_state = M_ERR; m_code = 3; end
        end else if (op >= 0) begin
            if (op == 5 && m_depth == 0) begin
                m_state = M_ERR; m_code = 2;
            end else if (m_cnt == CAP) begin
                m_state = M_ERR; m_code = 1;
            end else begin
                exp_q.push_back({4'(m_cnt), 3'(op)});
                m_cnt++;
                if (op == 4) m_depth++;
                if (op == 5) m_depth--;
            end
        end
    endtask

    // One clock: entered and left at a falling edge
    task automatic cycle(input logic s, input logic v, input logic [7:0] d);
        logic exp_rdy;
        start = s; rx_valid = v; rx_data = d;
        #1;
        exp_rdy = (m_state == M_RECV) && !s;
        chk("rx_ready", 32'(rx_ready), 32'(exp_rdy));
        if (s) begin
            m_state = M_RECV; m_cnt = 0; m_depth = 0; m_code = 0;
        end else if (v && exp_rdy) begin
            model_byte(d);
        end
        @(posedge CLK);
        @(negedge CLK);
        chk("prog_len", 32'(prog_len), 32'(m_cnt));
        chk("busy",     32'(busy),     32'(m_state == M_RECV));
        chk("loaded",   32'(loaded),   32'(m_state == M_DONE));
        chk("error",    32'(error),    32'(m_state == M_ERR));
        chk("err_code", 32'(err_code), 32'(m_code));
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) cycle(1'b0, 1'b0, 8'h00);
            cycle(1'b0, 1'b1, s[i]);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 1'b0; rx_valid = 1'b1; rx_data = "+";
        @(posedge CLK);
        @(negedge CLK);
        m_state = M_IDLE; m_cnt = 0; m_depth = 0; m_code = 0;
        chk("rst rx_ready",  32'(rx_ready),  0);
        chk("rst mem_we",    32'(mem_we),    0);
        chk("rst mem_addr",  32'(mem_addr),  0);
        chk("rst mem_wdata", 32'(mem_wdata), 0);
        chk("rst prog_len",  32'(prog_len),  0);
        chk("rst busy",      32'(busy),      0);
        chk("rst loaded",    32'(loaded),    0);
        chk("rst error",     32'(error),     0);
        chk("rst err_code",  32'(err_code),  0);
        chk("rst pending writes", 32'(exp_q.size()), 0);
        exp_q.delete();
        resetn = 1'b1; rx_valid = 1'b0;
    endtask

    // Monitor: every write strobe must match the oldest predicted write
    always @(negedge CLK) begin
        logic [6:0] e;
        chk("loaded/error exclusive", 32'(loaded && error), 0);
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected write at %0t: addr %0d data %0d, want none",
                         $time, mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("mem_addr",  32'(mem_addr),  32'(e[6:3]));
                chk("mem_wdata", 32'(mem_wdata), 32'(e[2:0]));
            end
        end
    end

    initial begin
        string pool;
        int    len;
        pool = "+-<>[].,[]]ab \n#";
        resetn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge CLK);
        do_reset();

        // Idle: nothing accepted
        cycle(1'b0, 1'b1, "+");

        // Basic load, then no more bytes accepted
        cycle(1'b1, 1'b0, 8'h00);
        send_str("+[->+<]!", 1'b0);
        cycle(1'b0, 1'b1, "+");

        // Comment filtering with gaps
        cycle(1'b1, 1'b0, 8'h00);
        send_str("a+ b\n-!", 1'b1);

        // Bracket errors
        cycle(1'b1, 1'b0, 8'h00);
        send_str("]!", 1'b0);
        cycle(1'b1, 1'b0, 8'h00);
        send_str("[[]!", 1'b0);

        // Overflow, then ']' on a full memory
        cycle(1'b1, 1'b0, 8'h00);
        send_str("+++++++++++++++++", 1'b0);
        cycle(1'b0, 1'b1, "+");
        cycle(1'b1, 1'b0, 8'h00);
        send_str("++++++++++++++++]!", 1'b0);

        // Restart mid-stream with a same-cycle byte, then reset mid-load
        cycle(1'b1, 1'b0, 8'h00);
        send_str("+>+<-", 1'b0);
        cycle(1'b1, 1'b1, "+");
        send_str("++[", 1'b0);
        do_reset();
        cycle(1'b0, 1'b1, "+");

        // Empty program
        cycle(1'b1, 1'b0, 8'h00);
        send_str("!", 1'b0);
        cycle(1'b0, 1'b1, "+");

        // Randomised programs with occasional restarts
        for (int it = 0; it < 60; it++) begin
            cycle(1'b1, 1'b0, 8'h00);
            len = $urandom_range(0, 22);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 8'h00);
                if ($urandom_range(0, 30) == 0)
                    cycle(1'b1, 1'($urandom_range(0, 1)), "+");
                cycle(1'b0, 1'b1, pool[$urandom_range(0, pool.len() - 1)]);
            end
            cycle(1'b0, 1'b1, 8'h21);
            cycle(1'b0, 1'b1, "+");
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        cycle(1'b0, 1'b0, 8'h00);
        chk("writes outstanding at end", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
